// File: rtl/fetch_stage.sv
// Instruction-fetch stage with PC register, next-PC selection and IF/ID pipeline register.
// Optional stall/flush performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             PCWrite,
    input  logic             IF_ID_WriteEn,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             jump_en,
    input  logic [31:0]      jump_target,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      imem_addr,
    output logic [31:0]      IF_ID_Instr,
    output logic [31:0]      IF_ID_PCplus4,
    output logic             IF_ID_Valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    output logic             fetch_fault
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;

    logic [31:0] pc_plus_step;
    logic        jump_accept;
    logic        flush;
    logic        misaligned;

    assign pc_plus_step = pc_q + 32'(PC_STEP);
    assign jump_accept  = jump_en & PCWrite;
    assign flush        = branch_taken | jump_accept;
    assign misaligned   = branch_taken ? (|branch_target[1:0])
                        : jump_accept  ? (|jump_target[1:0])
                        : 1'b0;

    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        fault_d = fault_q | misaligned;

        // A branch resolved in EX is older than anything in ID, so it beats a stall.
        if (branch_taken) begin
            pc_d = {branch_target[31:2], 2'b00};
        end else if (jump_accept) begin
            pc_d = {jump_target[31:2], 2'b00};
        end else if (PCWrite) begin
            pc_d = pc_plus_step;
        end

        if (flush) begin
            instr_d = 32'h0;
            pcp4_d  = 32'h0;
            valid_d = 1'b0;
        end else if (IF_ID_WriteEn) begin
            instr_d = imem_rdata;
            pcp4_d  = pc_plus_step;
            valid_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            pcp4_q  <= 32'h0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    assign imem_addr     = pc_q;
    assign IF_ID_Instr   = instr_q;
    assign IF_ID_PCplus4 = pcp4_q;
    assign IF_ID_Valid   = valid_q;
    assign fetch_fault   = fault_q;

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Both counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!PCWrite && !branch_taken && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the load-use hazard detector.
- Holds the PC, selects next PC (sequential / EX branch redirect / ID jump), drives instruction-memory address, latches fetched instruction into IF/ID.
- Obeys the detector's PCWrite and IF_ID_WriteEn; produces the IF_ID_Instr the detector and decode stage consume.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 4, sequential PC increment in bytes.
CNT_W, 16, width of performance counters (optional feature only).

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset_n  input  1  asynchronous, active-low reset.
PCWrite  input  1  1 = PC may advance; 0 = hold PC (load-use stall).
IF_ID_WriteEn  input  1  1 = IF/ID may load; 0 = hold IF/ID.
branch_taken  input  1  taken branch resolved in EX; redirect and flush.
branch_target  input  32  branch destination.
jump_en  input  1  jump decoded in ID; redirect and flush.
jump_target  input  32  jump destination.
imem_rdata  input  32  combinational instruction-memory read data for imem_addr.
imem_addr  output  32  current PC.
IF_ID_Instr  output  32  latched instruction (32'h0 = NOP bubble).
IF_ID_PCplus4  output  32  latched PC+PC_STEP of that instruction.
IF_ID_Valid  output  1  1 = IF/ID holds a real instruction.
fetch_fault  output  1  sticky: a redirect target was not word-aligned.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (reset_n=0, immediate): PC=RESET_PC, IF_ID_Instr=0, IF_ID_PCplus4=0, IF_ID_Valid=0, fetch_fault=0, counters=0. Holds while low; mid-operation assertion discards all in-flight state.
- imem_addr = PC combinationally; zero-cycle fetch, instruction enters IF/ID on the next edge (1-cycle latency).
- Next-PC priority, highest first:
  1. branch_taken=1 -> PC <= {branch_target[31:2],2'b00}; wins even when PCWrite=0.
  2. jump_en=1 and PCWrite=1 -> PC <= {jump_target[31:2],2'b00}.
  3. PCWrite=0 -> PC holds; jump_en ignored, since the stalled ID instruction re-presents it next cycle.
  4. Otherwise PC <= PC+PC_STEP, mod 2^32; 32'hFFFF_FFFC wraps to 0 with no flag.
- Flush condition F = branch_taken | (jump_en & PCWrite).
- IF/ID update priority:
  1. F -> Instr<=0, PCplus4<=0, Valid<=0 (bubble); flush beats IF_ID_WriteEn=0.
  2. IF_ID_WriteEn=0 -> all IF/ID fields hold.
  3. Otherwise Instr<=imem_rdata, PCplus4<=PC+PC_STEP, Valid<=1.
- PCWrite and IF_ID_WriteEn are expected equal; if they differ, each is honoured independently as above.
- fetch_fault: set on any edge where an accepted redirect (priority 1 or 2) has target[1:0]!=0. Cleared only by reset. The redirect still proceeds with low bits cleared.
- branch_taken and jump_en both high: branch wins, jump dropped, single flush.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs stall_cnt[CNT_W-1:0] and flush_cnt[CNT_W-1:0], both reset to 0.
  - stall_cnt: +1 each cycle PCWrite=0 and branch_taken=0.
  - flush_cnt: +1 each cycle F=1.
  - Both saturate at all-ones; no wrap.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset release, PCWrite=IF_ID_WriteEn=1, imem_rdata=0x20080005 -> imem_addr 0,4,8 on successive edges; after the first edge IF_ID_Instr=0x20080005, IF_ID_PCplus4=4, Valid=1.
- PC=0x10, PCWrite=IF_ID_WriteEn=0 for 2 cycles -> imem_addr stays 0x10, IF/ID unchanged, stall_cnt=2 (if enabled); release -> PC=0x14.
- PC=0x40, PCWrite=0, branch_taken=1, branch_target=0x100 -> next PC=0x100, IF_ID_Instr=0, Valid=0; fetch_fault=0.
- jump_en=1, jump_target=0x200, PCWrite=0 -> PC holds, no flush; next cycle PCWrite=1 -> PC=0x200, bubble, flush_cnt=1.
- branch_taken=1, target 0x102, plus jump_en=1, target 0x300 -> PC=0x100, fetch_fault=1 and stays 1 until reset_n=0.
- reset_n pulsed low mid-run with PC=0x80 -> outputs clear immediately without a clock edge; PC=RESET_PC.
